multicycle_ctrl: RTL and testbench

Multi-cycle control unit that drives the ALU's 4-bit `funct` port and the surrounding datapath strobes. It accepts one 32-bit MIPS instruction at a time over a valid/ready handshake and sequences it through DECODE / EXEC / MEM / WB. It issues the `ALU_*` operation codes from `GLOBAL.v` and consumes the ALU's 1-bit compare result. It sits between instruction fetch and the datapath of the multi-cycle CPU variant.

---
 rtl/multicycle_ctrl_pkg.sv | 103 ++++++++++
 rtl/multicycle_ctrl_if.sv | 31 +++
 rtl/multicycle_ctrl_alu_funct_decode.sv | 50 +++++
 rtl/multicycle_ctrl.sv | 136 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle control unit: ALU codes, opcode/funct values,
// selector encodings and FSM states. Defining CTRL_TRAP_EN adds the TRAP state.
package multicycle_ctrl_pkg;

  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_EQ   = 4'd12;
  localparam logic [3:0] ALU_NEQ  = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_SEXT = 2'b01;
  localparam logic [1:0] SRCB_ZEXT = 2'b10;

  localparam logic [1:0] REGDST_RD = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
`ifdef CTRL_TRAP_EN
    , ST_TRAP
`endif
  } state_t;

  typedef enum logic [3:0] {
    CLS_NOP = 4'd0,
    CLS_ALU_R,
    CLS_ALU_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_JAL,
    CLS_JR
  } inst_cls_t;

  typedef struct packed {
    logic [3:0] alu_funct;
    logic [1:0] alu_src_b;
    logic [1:0] reg_dst;
    inst_cls_t  cls;
    logic       legal;
  } dec_t;

  function automatic dec_t mk_dec(input logic [3:0] f, input logic [1:0] s,
                                  input logic [1:0] d, input inst_cls_t c);
    dec_t r;
    r.alu_funct = f;
    r.alu_src_b = s;
    r.reg_dst   = d;
    r.cls       = c;
    r.legal     = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Fetch handshake and datapath control bundle of the multi-cycle controller.
// master = fetch/datapath side, slave = controller.
interface multicycle_ctrl_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        alu_cond;
  logic [3:0]  alu_funct;
  logic [1:0]  alu_src_b;
  logic [1:0]  reg_dst;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        busy;
  logic        illegal_instr;

  modport master (
    output inst_valid, inst, alu_cond,
    input  inst_ready, alu_funct, alu_src_b, reg_dst, reg_write, mem_read,
           mem_write, mem_to_reg, pc_write, pc_src, busy, illegal_instr
  );

  modport slave (
    input  inst_valid, inst, alu_cond,
    output inst_ready, alu_funct, alu_src_b, reg_dst, reg_write, mem_read,
           mem_write, mem_to_reg, pc_write, pc_src, busy, illegal_instr
  );
endinterface

// File: rtl/multicycle_ctrl_alu_funct_decode.sv
// Combinational opcode/funct decoder: ALU operation, B-operand select, destination
// select, instruction class and legality.
module alu_funct_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output dec_t       o_dec
);

  always_comb begin
    o_dec = '{alu_funct: ALU_ADDU, alu_src_b: SRCB_RT, reg_dst: REGDST_RD,
              cls: CLS_NOP, legal: 1'b0};
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FUNCT_ADDU: o_dec = mk_dec(ALU_ADDU, SRCB_RT, REGDST_RD, CLS_ALU_R);
          FUNCT_SUBU: o_dec = mk_dec(ALU_SUBU, SRCB_RT, REGDST_RD, CLS_ALU_R);
          FUNCT_AND:  o_dec = mk_dec(ALU_AND,  SRCB_RT, REGDST_RD, CLS_ALU_R);
          FUNCT_OR:   o_dec = mk_dec(ALU_OR,   SRCB_RT, REGDST_RD, CLS_ALU_R);
          FUNCT_XOR:  o_dec = mk_dec(ALU_XOR,  SRCB_RT, REGDST_RD, CLS_ALU_R);
          FUNCT_NOR:  o_dec = mk_dec(ALU_NOR,  SRCB_RT, REGDST_RD, CLS_ALU_R);
          FUNCT_SLT:  o_dec = mk_dec(ALU_SLT,  SRCB_RT, REGDST_RD, CLS_ALU_R);
          FUNCT_SLTU: o_dec = mk_dec(ALU_SLTU, SRCB_RT, REGDST_RD, CLS_ALU_R);
          FUNCT_SLL:  o_dec = mk_dec(ALU_SLL,  SRCB_RT, REGDST_RD, CLS_ALU_R);
          FUNCT_SRL:  o_dec = mk_dec(ALU_SRL,  SRCB_RT, REGDST_RD, CLS_ALU_R);
          FUNCT_SRA:  o_dec = mk_dec(ALU_SRA,  SRCB_RT, REGDST_RD, CLS_ALU_R);
          FUNCT_JR:   o_dec = mk_dec(ALU_ADDU, SRCB_RT, REGDST_RD, CLS_JR);
          default:    ;
        endcase
      end
      OP_ADDIU: o_dec = mk_dec(ALU_ADDU, SRCB_SEXT, REGDST_RT, CLS_ALU_I);
      OP_SLTI:  o_dec = mk_dec(ALU_SLT,  SRCB_SEXT, REGDST_RT, CLS_ALU_I);
      OP_SLTIU: o_dec = mk_dec(ALU_SLTU, SRCB_SEXT, REGDST_RT, CLS_ALU_I);
      OP_ANDI:  o_dec = mk_dec(ALU_AND,  SRCB_ZEXT, REGDST_RT, CLS_ALU_I);
      OP_ORI:   o_dec = mk_dec(ALU_OR,   SRCB_ZEXT, REGDST_RT, CLS_ALU_I);
      OP_XORI:  o_dec = mk_dec(ALU_XOR,  SRCB_ZEXT, REGDST_RT, CLS_ALU_I);
      OP_LUI:   o_dec = mk_dec(ALU_LUI,  SRCB_ZEXT, REGDST_RT, CLS_ALU_I);
      OP_LW:    o_dec = mk_dec(ALU_ADDU, SRCB_SEXT, REGDST_RT, CLS_LOAD);
      // Stores never write the register file, so the destination select stays at rd.
      OP_SW:    o_dec = mk_dec(ALU_ADDU, SRCB_SEXT, REGDST_RD, CLS_STORE);
      OP_BEQ:   o_dec = mk_dec(ALU_EQ,   SRCB_RT,   REGDST_RD, CLS_BRANCH);
      OP_BNE:   o_dec = mk_dec(ALU_NEQ,  SRCB_RT,   REGDST_RD, CLS_BRANCH);
      OP_J:     o_dec = mk_dec(ALU_ADDU, SRCB_RT,   REGDST_RD, CLS_JUMP);
      OP_JAL:   o_dec = mk_dec(ALU_ADDU, SRCB_RT,   REGDST_RA, CLS_JAL);
      default:  ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with instruction latch. With CTRL_TRAP_EN defined,
// illegal instructions enter a sticky TRAP state; otherwise they retire as NOPs.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  multicycle_ctrl_if.slave bus
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_inst;
  dec_t        w_dec;
  logic        w_accept;
  logic        w_unused_fields;

  logic [3:0]  w_alu_funct;
  logic [1:0]  w_alu_src_b;
  logic [1:0]  w_reg_dst;
  logic        w_reg_write;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_mem_to_reg;
  logic        w_pc_write;
  logic [1:0]  w_pc_src;
  logic        w_busy;
  logic        w_illegal;

  assign bus.inst_ready = (r_state == ST_IDLE) & ~reset;
  assign w_accept       = bus.inst_valid & bus.inst_ready;

  alu_funct_decode u_decode (
    .i_opcode (r_inst[31:26]),
    .i_funct  (r_inst[5:0]),
    .o_dec    (w_dec)
  );

  // Register and immediate fields belong to the datapath, not to sequencing.
  assign w_unused_fields = ^{r_inst[25:6], w_dec.legal};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_inst <= bus.inst;
  end

  always_comb begin
    w_next       = r_state;
    w_alu_funct  = ALU_ADDU;
    w_alu_src_b  = SRCB_RT;
    w_reg_dst    = REGDST_RD;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = PCSRC_SEQ;
    w_busy       = (r_state != ST_IDLE);
    w_illegal    = 1'b0;

    if (r_state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
      w_alu_funct = w_dec.alu_funct;
      w_alu_src_b = w_dec.alu_src_b;
      w_reg_dst   = w_dec.reg_dst;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_DECODE;
      end
      ST_DECODE: begin
        w_next = ST_EXEC;
`ifdef CTRL_TRAP_EN
        if (!w_dec.legal) w_next = ST_TRAP;
`endif
      end
      ST_EXEC: begin
        case (w_dec.cls)
          CLS_ALU_R, CLS_ALU_I, CLS_JAL: w_next = ST_WB;
          CLS_LOAD, CLS_STORE:           w_next = ST_MEM;
          default: begin
            // Branches, jumps and NOPs retire here; alu_cond is settled by now.
            w_next     = ST_IDLE;
            w_pc_write = 1'b1;
            case (w_dec.cls)
              CLS_BRANCH: w_pc_src = bus.alu_cond ? PCSRC_BRANCH : PCSRC_SEQ;
              CLS_JUMP:   w_pc_src = PCSRC_JUMP;
              CLS_JR:     w_pc_src = PCSRC_REG;
              default:    w_pc_src = PCSRC_SEQ;
            endcase
          end
        endcase
      end
      ST_MEM: begin
        w_mem_read  = (w_dec.cls == CLS_LOAD);
        w_mem_write = (w_dec.cls == CLS_STORE);
        if (w_dec.cls == CLS_LOAD) begin
          w_next = ST_WB;
        end else begin
          w_next     = ST_IDLE;
          w_pc_write = 1'b1;
        end
      end
      ST_WB: begin
        w_next       = ST_IDLE;
        w_reg_write  = 1'b1;
        w_mem_to_reg = (w_dec.cls == CLS_LOAD);
        w_pc_write   = 1'b1;
        w_pc_src     = (w_dec.cls == CLS_JAL) ? PCSRC_JUMP : PCSRC_SEQ;
      end
`ifdef CTRL_TRAP_EN
      ST_TRAP: begin
        w_illegal = 1'b1;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  assign bus.alu_funct     = w_alu_funct;
  assign bus.alu_src_b     = w_alu_src_b;
  assign bus.reg_dst       = w_reg_dst;
  assign bus.reg_write     = w_reg_write;
  assign bus.mem_read      = w_mem_read;
  assign bus.mem_write     = w_mem_write;
  assign bus.mem_to_reg    = w_mem_to_reg;
  assign bus.pc_write      = w_pc_write;
  assign bus.pc_src        = w_pc_src;
  assign bus.busy          = w_busy;
  assign bus.illegal_instr = w_illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed and random instructions, reference
// model predicts every cycle's outputs; honours CTRL_TRAP_EN if defined.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  multicycle_ctrl_if bus();

  multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] funct;
    logic [1:0] src_b;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       busy;
    logic       illegal;
    logic       ready;
  } obs_t;

  typedef struct {
    obs_t  o;
    string tag;
  } exp_t;

  typedef enum int {K_R, K_I, K_LW, K_SW, K_BR, K_J, K_JAL, K_JR, K_BAD} kind_e;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic obs_t sample();
    obs_t o;
    o.funct      = bus.alu_funct;
    o.src_b      = bus.alu_src_b;
    o.reg_dst    = bus.reg_dst;
    o.reg_write  = bus.reg_write;
    o.mem_read   = bus.mem_read;
    o.mem_write  = bus.mem_write;
    o.mem_to_reg = bus.mem_to_reg;
    o.pc_write   = bus.pc_write;
    o.pc_src     = bus.pc_src;
    o.busy       = bus.busy;
    o.illegal    = bus.illegal_instr;
    o.ready      = bus.inst_ready;
    return o;
  endfunction

  function automatic obs_t idle_obs(input logic rdy);
    obs_t o;
    o = '0;
    o.funct = ALU_ADDU;
    o.ready = rdy;
    return o;
  endfunction

  function automatic void check(input string tag, input obs_t got, input obs_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%05h exp=%05h (funct,srcb,dst,rw,mr,mw,m2r,pcw,pcsrc,busy,ill,rdy)",
               tag, got, exp);
    end
  endfunction

  function automatic void push(input obs_t o, input string tag);
    exp_t e;
    e.o = o;
    e.tag = tag;
    exp_q.push_back(e);
  endfunction

  // Instruction-set view of the decoder: class, ALU code, B source, destination.
  function automatic void ref_decode(input logic [31:0] ins, output kind_e k,
                                     output logic [3:0] f, output logic [1:0] s,
                                     output logic [1:0] d);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    k = K_BAD; f = ALU_ADDU; s = 2'd0; d = 2'd0;
    case (op)
      6'h00: begin
        k = K_R;
        case (fn)
          6'h21: f = ALU_ADDU;
          6'h23: f = ALU_SUBU;
          6'h24: f = ALU_AND;
          6'h25: f = ALU_OR;
          6'h26: f = ALU_XOR;
          6'h27: f = ALU_NOR;
          6'h2A: f = ALU_SLT;
          6'h2B: f = ALU_SLTU;
          6'h00: f = ALU_SLL;
          6'h02: f = ALU_SRL;
          6'h03: f = ALU_SRA;
          6'h08: k = K_JR;
          default: k = K_BAD;
        endcase
      end
      6'h09: begin k = K_I; f = ALU_ADDU; s = 2'd1; d = 2'd1; end
      6'h0A: begin k = K_I; f = ALU_SLT;  s = 2'd1; d = 2'd1; end
      6'h0B: begin k = K_I; f = ALU_SLTU; s = 2'd1; d = 2'd1; end
      6'h0C: begin k = K_I; f = ALU_AND;  s = 2'd2; d = 2'd1; end
      6'h0D: begin k = K_I; f = ALU_OR;   s = 2'd2; d = 2'd1; end
      6'h0E: begin k = K_I; f = ALU_XOR;  s = 2'd2; d = 2'd1; end
      6'h0F: begin k = K_I; f = ALU_LUI;  s = 2'd2; d = 2'd1; end
      6'h23: begin k = K_LW; s = 2'd1; d = 2'd1; end
      6'h2B: begin k = K_SW; s = 2'd1; end
      6'h04: begin k = K_BR; f = ALU_EQ; end
      6'h05: begin k = K_BR; f = ALU_NEQ; end
      6'h02: k = K_J;
      6'h03: begin k = K_JAL; d = 2'd2; end
      default: ;
    endcase
  endfunction

  function automatic bit is_bad(input logic [31:0] ins);
    kind_e k; logic [3:0] f; logic [1:0] s, d;
    ref_decode(ins, k, f, s, d);
    return k == K_BAD;
  endfunction

  // Push one record per cycle from the cycle after accept; returns busy-cycle count.
  function automatic int expect_inst(input logic [31:0] ins, input logic cond, input string tag);
    kind_e k; logic [3:0] f; logic [1:0] s, d, tgt; int len; bit wr;
    obs_t o, r;
    ref_decode(ins, k, f, s, d);
    o = idle_obs(1'b0);
    o.funct = f; o.src_b = s; o.reg_dst = d; o.busy = 1'b1;
`ifdef CTRL_TRAP_EN
    if (k == K_BAD) begin
      push(o, $sformatf("%s/c1", tag));
      o = idle_obs(1'b0);
      o.busy = 1'b1; o.illegal = 1'b1;
      for (int i = 0; i < 4; i++) push(o, $sformatf("%s/trap%0d", tag, i));
      return 5;
    end
`endif
    if (k == K_LW) len = 4;
    else if (k inside {K_R, K_I, K_SW, K_JAL}) len = 3;
    else len = 2;
    wr = (k inside {K_R, K_I, K_LW, K_JAL});
    case (k)
      K_BR:       tgt = cond ? 2'd1 : 2'd0;
      K_J, K_JAL: tgt = 2'd2;
      K_JR:       tgt = 2'd3;
      default:    tgt = 2'd0;
    endcase
    for (int c = 1; c <= len; c++) begin
      r = o;
      r.reg_write  = wr && (c == len);
      r.mem_read   = (k == K_LW) && (c == 3);
      r.mem_write  = (k == K_SW) && (c == 3);
      r.mem_to_reg = (k == K_LW) && (c == len);
      r.pc_write   = (c == len);
      r.pc_src     = (c == len) ? tgt : 2'd0;
      push(r, $sformatf("%s/c%0d", tag, c));
    end
    push(idle_obs(1'b1), $sformatf("%s/idle", tag));
    return len;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.tag, sample(), e.o);
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic cond, input bit hold, input string tag);
    int n;
    int len;
    n = 0;
    @(negedge clk);
    while (bus.inst_ready !== 1'b1) begin
      if (n == 40) begin
        vectors++; miscompares++;
        $display("FAIL %s/ready_timeout got inst_ready=%b exp 1", tag, bus.inst_ready);
        return;
      end
      @(negedge clk);
      n++;
    end
    bus.inst = ins; bus.alu_cond = cond; bus.inst_valid = 1'b1;
    @(posedge clk);
    len = expect_inst(ins, cond, tag);
    #1;
    if (hold) begin
      repeat (len + 1) @(negedge clk);
    end
    bus.inst_valid = 1'b0;
    bus.inst = $urandom;
  endtask

  task automatic recover_reset(input string tag);
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    exp_q.delete();
    #1 check($sformatf("%s/rst", tag), sample(), idle_obs(1'b0));
    @(negedge clk) reset = 1'b0;
    #1 check($sformatf("%s/rel", tag), sample(), idle_obs(1'b1));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, queue=%0d exp 0", exp_q.size());
    $fatal(1, "watchdog");
  end

  logic [5:0] legal_fn [12] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08};
  logic [5:0] legal_op [13] = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};

  initial begin : stim
    logic [31:0] ins;
    int r;
    int n;
    reset = 1'b1;
    bus.inst_valid = 1'b0; bus.inst = '0; bus.alu_cond = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("reset_state", sample(), idle_obs(1'b0));
    @(negedge clk) reset = 1'b0;
    #1 check("idle_after_reset", sample(), idle_obs(1'b1));

    issue(32'h00221821, 1'b0, 1'b0, "addu");
    issue(32'h8C850008, 1'b1, 1'b0, "lw");
    issue(32'h10220004, 1'b1, 1'b0, "beq_taken");
    issue(32'h10220004, 1'b0, 1'b0, "beq_not_taken");
    issue(32'h14220004, 1'b1, 1'b0, "bne");
    issue(32'h3C011234, 1'b0, 1'b0, "lui");
    issue(32'h0C000010, 1'b0, 1'b0, "jal");
    issue(32'h08000010, 1'b0, 1'b0, "j");
    issue(32'h03E00008, 1'b1, 1'b0, "jr");
    issue(32'hAC850008, 1'b0, 1'b0, "sw");
    issue(32'h00221821, 1'b0, 1'b1, "addu_valid_held");
    issue(32'hFC000000, 1'b0, 1'b0, "illegal_op");
    recover_reset("illegal_op");

    // Reset during MEM of a store: strobes must drop before the next edge.
    issue(32'hAC850008, 1'b0, 1'b0, "sw_reset");
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    exp_q.delete();
    #1 check("sw_reset/async", sample(), idle_obs(1'b0));
    @(posedge clk);
    #1 check("sw_reset/held", sample(), idle_obs(1'b0));
    @(negedge clk) reset = 1'b0;
    #1 check("sw_reset/released", sample(), idle_obs(1'b1));
    issue(32'h8C850008, 1'b0, 1'b0, "lw_after_reset");

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 15);
      ins = $urandom;
      if (r <= 4) begin
        ins[31:26] = 6'h00;
        ins[5:0] = legal_fn[$urandom_range(0, 11)];
      end else if (r == 5) begin
        ins[31:26] = 6'h00;
      end else if (r <= 14) begin
        ins[31:26] = legal_op[$urandom_range(0, 12)];
      end
      issue(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $sformatf("rnd%0d_%08h", i, ins));
      if (is_bad(ins)) recover_reset($sformatf("rnd%0d_bad", i));
    end

    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      vectors++; miscompares++;
      $display("FAIL drain: got %0d pending records exp 0", exp_q.size());
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
